// File: rtl/parity_arbiter.sv
// ---------------------------------------------------------------------------
// parity_arbiter
//
// Purpose:
//   Lets NREQ protected-storage clients share one combinational parity
//   generator. A round-robin arbiter picks one requester per cycle, the
//   chosen word goes through the single Parity instance, and the result is
//   returned as a registered response tagged with the requester index.
//   Parity mismatches are counted in a saturating error counter that the
//   error-reporting logic can read and clear.
//
// Modules in this file:
//   Parity          combinational parity of a WIDTH-bit word (even or odd)
//   parity_arbiter  top level: arbiter, grant mux, response register,
//                   error counter
//
// Port summary (parity_arbiter):
//   clk        in   1             clock, all state changes on posedge
//   rst        in   1             synchronous active-high reset
//   req_valid  in   NREQ          per-requester request valid
//   req_ready  out  NREQ          per-requester accept, one-hot or zero
//   req_data   in   NREQ*WIDTH    requester i at [i*WIDTH +: WIDTH]
//   req_check  in   NREQ          1 = compare parity against req_exp
//   req_exp    in   NREQ          expected parity bit per requester
//   rsp_valid  out  1             response register holds a result
//   rsp_ready  in   1             consumer takes the response
//   rsp_id     out  $clog2(NREQ)  requester that produced the response
//   rsp_parity out  1             computed parity of the granted word
//   rsp_err    out  1             checked and computed != expected
//   err_clr    in   1             synchronous clear of err_count
//   err_count  out  CNT_WIDTH     saturating count of erroring responses
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// Parity
//   data_i    in   WIDTH  word to protect
//   parity_o  out  1      XOR of all bits (ODD=0) or XNOR of all bits (ODD=1)
// ---------------------------------------------------------------------------
module Parity #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    localparam logic OddSense = (ODD != 0);

    // Odd sense is the even parity inverted.
    assign parity_o = (^data_i) ^ OddSense;

endmodule

module parity_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int CNT_WIDTH = 8,
    parameter int ODD       = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NREQ-1:0]                              req_valid,
    output logic [NREQ-1:0]                              req_ready,
    input  logic [NREQ*WIDTH-1:0]                        req_data,
    input  logic [NREQ-1:0]                              req_check,
    input  logic [NREQ-1:0]                              req_exp,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]   rsp_id,
    output logic                                         rsp_parity,
    output logic                                         rsp_err,
    input  logic                                         err_clr,
    output logic [CNT_WIDTH-1:0]                         err_count
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW-1:0] LastIdx = IDW'(NREQ - 1);

    // Registered state
    logic [IDW-1:0]       ptr_q,       ptr_d;
    logic                 rspValid_q,  rspValid_d;
    logic [IDW-1:0]       rspId_q,     rspId_d;
    logic                 rspParity_q, rspParity_d;
    logic                 rspErr_q,    rspErr_d;
    logic [CNT_WIDTH-1:0] errCount_q,  errCount_d;

    // Arbitration and grant-mux signals
    logic                 grantFound;
    logic [IDW-1:0]       grantIdx;
    logic [IDW-1:0]       candIdx;
    int                   candSum;
    logic                 space;
    logic                 accept;
    logic [NREQ-1:0]      reqReady;
    logic [WIDTH-1:0]     selWord;
    logic                 selCheck;
    logic                 selExp;
    logic                 selParity;
    logic                 selErr;

    // Round-robin search: walk the requesters starting at the pointer and
    // wrapping past the last index; the first one with valid set wins.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        candSum    = 0;
        for (int k = 0; k < NREQ; k++) begin
            candSum = (int'(ptr_q) + k) % NREQ;
            candIdx = IDW'(candSum);
            if (!grantFound && req_valid[candIdx]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // The response register can take a new word when it is empty or is
    // being drained on this same edge, so full-rate streaming needs no
    // bubble. Reset suppresses every grant.
    assign space  = !rspValid_q || rsp_ready;
    assign accept = !rst && grantFound && space;

    always_comb begin
        reqReady = '0;
        if (!rst && grantFound) begin
            reqReady[grantIdx] = space;
        end
    end

    assign req_ready = reqReady;

    // Grant mux: only the winner's word, check flag and expected bit are
    // routed to the shared parity generator.
    always_comb begin
        selWord  = '0;
        selCheck = 1'b0;
        selExp   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantIdx == IDW'(i)) begin
                selWord  = req_data[i*WIDTH +: WIDTH];
                selCheck = req_check[i];
                selExp   = req_exp[i];
            end
        end
    end

    Parity #(
        .WIDTH (WIDTH),
        .ODD   (ODD)
    ) u_parity (
        .data_i   (selWord),
        .parity_o (selParity)
    );

    assign selErr = selCheck && (selParity != selExp);

    // Response register and pointer next state. A drain without a new
    // grant only clears valid; the payload fields keep their last values.
    // Under backpressure nothing is accepted, so everything holds.
    always_comb begin
        ptr_d       = ptr_q;
        rspValid_d  = rspValid_q;
        rspId_d     = rspId_q;
        rspParity_d = rspParity_q;
        rspErr_d    = rspErr_q;
        if (accept) begin
            rspValid_d  = 1'b1;
            rspId_d     = grantIdx;
            rspParity_d = selParity;
            rspErr_d    = selErr;
            ptr_d       = (grantIdx == LastIdx) ? '0 : grantIdx + IDW'(1);
        end else if (rspValid_q && rsp_ready) begin
            rspValid_d = 1'b0;
        end
    end

    // Error counter: clear wins over a coincident increment, and the count
    // sticks at all-ones instead of wrapping.
    always_comb begin
        errCount_d = errCount_q;
        if (err_clr) begin
            errCount_d = '0;
        end else if (accept && selErr && (errCount_q != {CNT_WIDTH{1'b1}})) begin
            errCount_d = errCount_q + CNT_WIDTH'(1);
        end
    end

    // State registers. Reset discards any pending response without a
    // handshake and restarts the arbitration search at requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rspValid_q  <= 1'b0;
            rspId_q     <= '0;
            rspParity_q <= 1'b0;
            rspErr_q    <= 1'b0;
            errCount_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rspValid_q  <= rspValid_d;
            rspId_q     <= rspId_d;
            rspParity_q <= rspParity_d;
            rspErr_q    <= rspErr_d;
            errCount_q  <= errCount_d;
        end
    end

    assign rsp_valid  = rspValid_q;
    assign rsp_id     = rspId_q;
    assign rsp_parity = rspParity_q;
    assign rsp_err    = rspErr_q;
    assign err_count  = errCount_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// ---------------------------------------------------------------------------
// tb_parity_arbiter
//
// Drives two copies of parity_arbiter (even and odd parity sense) with the
// same directed stimulus. A behavioural model of the arbiter is compared
// against both copies on every negative clock edge once reset has been
// seen, and directed literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_parity_arbiter;

    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int CNT_WIDTH = 8;
    localparam int CNT_MAX   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  reqValid;
    logic [31:0] reqData;
    logic [3:0]  reqCheck;
    logic [3:0]  reqExp;
    logic        rspReady;
    logic        errClr;

    logic [3:0]  reqReady0,  reqReady1;
    logic        rspValid0,  rspValid1;
    logic [1:0]  rspId0,     rspId1;
    logic        rspParity0, rspParity1;
    logic        rspErr0,    rspErr1;
    logic [7:0]  errCount0,  errCount1;

    int checks = 0;
    int errors = 0;

    // Clock generation
    always #5 clk = ~clk;

    parity_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .CNT_WIDTH(CNT_WIDTH), .ODD(0)
    ) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid),
        .req_ready  (reqReady0),
        .req_data   (reqData),
        .req_check  (reqCheck),
        .req_exp    (reqExp),
        .rsp_valid  (rspValid0),
        .rsp_ready  (rspReady),
        .rsp_id     (rspId0),
        .rsp_parity (rspParity0),
        .rsp_err    (rspErr0),
        .err_clr    (errClr),
        .err_count  (errCount0)
    );

    parity_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .CNT_WIDTH(CNT_WIDTH), .ODD(1)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (reqValid),
        .req_ready  (reqReady1),
        .req_data   (reqData),
        .req_check  (reqCheck),
        .req_exp    (reqExp),
        .rsp_valid  (rspValid1),
        .rsp_ready  (rspReady),
        .rsp_id     (rspId1),
        .rsp_parity (rspParity1),
        .rsp_err    (rspErr1),
        .err_clr    (errClr),
        .err_count  (errCount1)
    );

    // Single comparison point shared by the model checker and directed tests
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Behavioural model state: which requester is next in line, whether a
    // response is held, its contents, and the error count of each copy.
    bit mRun = 1'b0;
    int mPtr;
    bit mValid;
    int mId;
    bit mPar [2];
    bit mErr [2];
    int mCnt [2];

    int         wSel;
    bit         mAcc;
    logic [7:0] mWord;
    bit         mEven;
    bit         mP;
    bit         mE;

    // First requester with valid set, looking from the model pointer onward
    // with wrap-around; -1 when nobody is asking.
    function automatic int winner();
        for (int off = 0; off < NREQ; off++) begin
            if (reqValid[(mPtr + off) % NREQ]) return (mPtr + off) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] expReady();
        int w;
        logic [3:0] r;
        r = 4'b0000;
        w = winner();
        if (!rst && w >= 0 && (!mValid || rspReady)) r[w] = 1'b1;
        return r;
    endfunction

    // Model update on every active edge
    always @(posedge clk) begin
        if (rst) begin
            mRun   = 1'b1;
            mPtr   = 0;
            mValid = 1'b0;
            mId    = 0;
            for (int d = 0; d < 2; d++) begin
                mPar[d] = 1'b0;
                mErr[d] = 1'b0;
                mCnt[d] = 0;
            end
        end else if (mRun) begin
            wSel = winner();
            mAcc = (wSel >= 0) && (!mValid || rspReady);
            for (int d = 0; d < 2; d++) begin
                mE = 1'b0;
                if (mAcc) begin
                    mWord = reqData[wSel*WIDTH +: WIDTH];
                    mEven = ($countones(mWord) % 2) == 1;
                    mP    = (d == 1) ? !mEven : mEven;
                    mE    = reqCheck[wSel] && (mP != reqExp[wSel]);
                    mPar[d] = mP;
                    mErr[d] = mE;
                end
                if (errClr) mCnt[d] = 0;
                else if (mE && mCnt[d] < CNT_MAX) mCnt[d] = mCnt[d] + 1;
            end
            if (mAcc) begin
                mValid = 1'b1;
                mId    = wSel;
                mPtr   = (wSel + 1) % NREQ;
            end else if (mValid && rspReady) begin
                mValid = 1'b0;
            end
        end
    end

    // Compare both copies against the model mid-cycle
    always @(negedge clk) begin
        if (mRun) begin
            checkOutput("req_ready0",  {28'd0, reqReady0}, {28'd0, expReady()});
            checkOutput("req_ready1",  {28'd0, reqReady1}, {28'd0, expReady()});
            checkOutput("rsp_valid0",  {31'd0, rspValid0}, {31'd0, mValid});
            checkOutput("rsp_valid1",  {31'd0, rspValid1}, {31'd0, mValid});
            checkOutput("rsp_id0",     {30'd0, rspId0}, mId);
            checkOutput("rsp_id1",     {30'd0, rspId1}, mId);
            checkOutput("rsp_parity0", {31'd0, rspParity0}, {31'd0, mPar[0]});
            checkOutput("rsp_parity1", {31'd0, rspParity1}, {31'd0, mPar[1]});
            checkOutput("rsp_err0",    {31'd0, rspErr0}, {31'd0, mErr[0]});
            checkOutput("rsp_err1",    {31'd0, rspErr1}, {31'd0, mErr[1]});
            checkOutput("err_count0",  {24'd0, errCount0}, mCnt[0]);
            checkOutput("err_count1",  {24'd0, errCount1}, mCnt[1]);
        end
    end

    task automatic applyStimulus(input logic r, input logic [3:0] v,
                                 input logic [31:0] d, input logic [3:0] c,
                                 input logic [3:0] e, input logic rr,
                                 input logic clr);
        rst      = r;
        reqValid = v;
        reqData  = d;
        reqCheck = c;
        reqExp   = e;
        rspReady = rr;
        errClr   = clr;
    endtask

    task automatic nextHalf();
        @(negedge clk);
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] expGrant;

    initial begin
        applyStimulus(1'b1, 4'hF, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);

        // Reset: ready held low even with every requester asking
        nextEdge();
        nextHalf();
        checkOutput("rst_ready",     {28'd0, reqReady0}, 32'h0);
        checkOutput("rst_rsp_valid", {31'd0, rspValid0}, 32'h0);
        checkOutput("rst_rsp_id",    {30'd0, rspId0},    32'h0);
        checkOutput("rst_err_count", {24'd0, errCount0}, 32'h0);
        nextEdge();

        // Single requester 2 with 8'hAA, checked against expected 0
        applyStimulus(1'b0, 4'b0100, 32'h00AA_0000, 4'b0100, 4'b0000, 1'b1, 1'b0);
        nextHalf();
        checkOutput("single_ready", {28'd0, reqReady0}, 32'h4);
        nextEdge();
        checkOutput("single_valid",   {31'd0, rspValid0},  32'h1);
        checkOutput("single_id",      {30'd0, rspId0},     32'h2);
        checkOutput("single_parity",  {31'd0, rspParity0}, 32'h0);
        checkOutput("single_err",     {31'd0, rspErr0},    32'h0);
        checkOutput("single_count",   {24'd0, errCount0},  32'h0);
        checkOutput("single_parity1", {31'd0, rspParity1}, 32'h1);
        checkOutput("single_count1",  {24'd0, errCount1},  32'h1);

        // Round robin from a fresh pointer with everyone asking
        applyStimulus(1'b1, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        nextEdge();
        checkOutput("rst2_valid", {31'd0, rspValid0}, 32'h0);
        applyStimulus(1'b0, 4'hF, 32'h8001_7F03, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            expGrant = 4'b0000;
            expGrant[i % 4] = 1'b1;
            nextHalf();
            checkOutput("rr_ready", {28'd0, reqReady0}, {28'd0, expGrant});
            nextEdge();
            checkOutput("rr_id", {30'd0, rspId0}, i % 4);
        end

        // Backpressure: three stalled cycles, then resume at requester 2
        applyStimulus(1'b0, 4'hF, 32'h8001_7F03, 4'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            nextHalf();
            checkOutput("bp_ready", {28'd0, reqReady0}, 32'h0);
            nextEdge();
            checkOutput("bp_valid", {31'd0, rspValid0}, 32'h1);
            checkOutput("bp_id",    {30'd0, rspId0},    32'h1);
        end
        applyStimulus(1'b0, 4'hF, 32'h8001_7F03, 4'h0, 4'h0, 1'b1, 1'b0);
        nextHalf();
        checkOutput("bp_resume_ready", {28'd0, reqReady0}, 32'h4);
        nextEdge();
        checkOutput("bp_resume_id", {30'd0, rspId0}, 32'h2);

        // Requester 1 sends 8'h01 checked against 0: an error each time
        applyStimulus(1'b0, 4'b0010, 32'h0000_0100, 4'b0010, 4'b0000, 1'b1, 1'b0);
        nextEdge();
        checkOutput("err_parity", {31'd0, rspParity0}, 32'h1);
        checkOutput("err_flag",   {31'd0, rspErr0},    32'h1);
        checkOutput("err_count",  {24'd0, errCount0},  32'h1);
        checkOutput("err_count1", {24'd0, errCount1},  32'h0);
        repeat (300) nextEdge();
        checkOutput("sat_count", {24'd0, errCount0}, 32'hFF);
        checkOutput("sat_err",   {31'd0, rspErr0},   32'h1);

        // Same word unchecked: no error and the count stays put
        applyStimulus(1'b0, 4'b0010, 32'h0000_0100, 4'b0000, 4'b0000, 1'b1, 1'b0);
        repeat (5) nextEdge();
        checkOutput("nocheck_err",   {31'd0, rspErr0},   32'h0);
        checkOutput("nocheck_count", {24'd0, errCount0}, 32'hFF);

        // Clear on the same edge as an erroring accept wins
        applyStimulus(1'b0, 4'b0010, 32'h0000_0100, 4'b0010, 4'b0000, 1'b1, 1'b1);
        nextEdge();
        checkOutput("clr_count", {24'd0, errCount0}, 32'h0);
        applyStimulus(1'b0, 4'b0010, 32'h0000_0100, 4'b0010, 4'b0000, 1'b1, 1'b0);
        nextEdge();
        checkOutput("after_clr_count", {24'd0, errCount0}, 32'h1);

        // All-zero word: even sense gives 0, odd sense gives 1
        applyStimulus(1'b0, 4'b0001, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        nextEdge();
        checkOutput("zero_parity0", {31'd0, rspParity0}, 32'h0);
        checkOutput("zero_parity1", {31'd0, rspParity1}, 32'h1);
        checkOutput("zero_id",      {30'd0, rspId0},     32'h0);

        // Move the pointer to 2 with a response pending, then reset
        applyStimulus(1'b0, 4'b0010, 32'h0000_0300, 4'h0, 4'h0, 1'b1, 1'b0);
        nextEdge();
        checkOutput("pre_rst_valid", {31'd0, rspValid0}, 32'h1);
        applyStimulus(1'b1, 4'b1001, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        nextHalf();
        checkOutput("mid_rst_ready", {28'd0, reqReady0}, 32'h0);
        nextEdge();
        checkOutput("mid_rst_valid0", {31'd0, rspValid0}, 32'h0);
        checkOutput("mid_rst_valid1", {31'd0, rspValid1}, 32'h0);
        applyStimulus(1'b0, 4'b1001, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        nextHalf();
        checkOutput("post_rst_ready", {28'd0, reqReady0}, 32'h1);
        nextEdge();
        checkOutput("post_rst_id",    {30'd0, rspId0},    32'h0);
        checkOutput("post_rst_valid", {31'd0, rspValid0}, 32'h1);

        // Drain with no new request: valid drops, id holds
        applyStimulus(1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        nextEdge();
        checkOutput("drain_valid", {31'd0, rspValid0}, 32'h0);
        checkOutput("drain_id",    {30'd0, rspId0},    32'h0);
        repeat (2) nextEdge();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
